// File: rtl/alu_rf_sequencer_pkg.sv
// Shared widths, ALU opcode encodings and FSM state encoding for the
// ALU/register-file command sequencer.
package alu_rf_sequencer_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/alu_rf_sequencer.sv
// Serialises one command at a time through an external register file and ALU:
// read operands, execute, write back (unless rd=0), then hold a response.
module alu_rf_sequencer
    import alu_rf_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_rs1,
    input  logic [ADDR_WIDTH-1:0] cmd_rs2,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wen,
    output logic [2:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [2:0]            alu_flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [2:0]            rsp_flag,
    output logic [31:0]           done_count
);

    state_e                state, state_next;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
    logic [DATA_WIDTH-1:0] opa_q, opb_q, res_q;
    logic [2:0]            flag_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_next = ST_READ;
            ST_READ:  state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_WRITE;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rf_wen    = (state == ST_WRITE) && (rd_q != '0);
        rsp_valid = (state == ST_RESP);
        alu_op    = (state == ST_EXEC) ? op_q : '0;
    end

    // Address/data outputs come straight from registers so they hold between uses.
    assign rf_raddr1  = rs1_q;
    assign rf_raddr2  = rs2_q;
    assign alu_a      = opa_q;
    assign alu_b      = opb_q;
    assign rf_waddr   = rd_q;
    assign rf_wdata   = res_q;
    assign rsp_result = res_q;
    assign rsp_flag   = flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            res_q      <= '0;
            flag_q     <= '0;
            done_count <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    op_q  <= cmd_op;
                    rd_q  <= cmd_rd;
                    rs1_q <= cmd_rs1;
                    rs2_q <= cmd_rs2;
                end
                ST_READ: begin
                    opa_q <= rf_rdata1;
                    opb_q <= rf_rdata2;
                end
                ST_EXEC: begin
                    res_q  <= alu_result;
                    flag_q <= alu_flag;
                end
                ST_RESP: if (rsp_ready) done_count <= done_count + 32'd1;
                default: ;
            endcase
        end
    end

endmodule
